rf_writeback_queue: RTL and testbench
=====================================

Name: rf_writeback_queue

Overview:
- Write-side front end for the 16 x 32-bit register file: accepts result writes from the execute/memory stages via valid/ready, buffers them in a DEPTH-entry FIFO, and drives the register file's write port (load enable, 4-bit destination select, 32-bit data) at one write per cycle.
- Keeps a per-register pending scoreboard so decode can detect read-after-write hazards on its three read selects.
- A write to R15 also emits a PC-redirect pulse.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
CW, $clog2(DEPTH+2), width of each per-register pending counter

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-low reset
wb_valid  in  1  producer has a write
wb_ready  out  1  queue can accept; equals !full
wb_rd  in  4  destination register
wb_data  in  32  write data
rf_hold  in  1  freeze draining; no pop while high
rf_lde  out  1  register-file load enable, registered
rf_dsel  out  4  register-file destination select, registered
rf_din  out  32  register-file write data, registered
pc_load  out  1  one-cycle pulse, coincident with rf_lde, when rf_dsel==15
chk_s1, chk_s2, chk_s3  in  4 each  decode read selects
hz1, hz2, hz3  out  1 each  combinational: selected register has a pending write
fwd_hit1..3  out  1 each  forwarding hit (see Optional Feature)
fwd_data1..3  out  32 each  forwarding data (see Optional Feature)
q_count  out  CW  entries currently in the FIFO

Behaviour:
- Reset (clr low, asynchronous, at any time):
  - FIFO emptied; all 16 pending counters = 0.
  - rf_lde = 0, rf_dsel = 0, rf_din = 0, pc_load = 0, q_count = 0.
  - In-flight writes are discarded and never reach the register file.
- Push: at a rising edge with wb_valid && wb_ready, store {wb_rd, wb_data} at the tail. No same-cycle bypass into the output stage.
- Full: wb_ready = 0 when q_count == DEPTH. A push and a pop in the same cycle while full is not allowed, because wb_ready is already low.
- Pop: at a rising edge with q_count > 0 && !rf_hold, load the head into the output stage (rf_lde = 1, rf_dsel, rf_din) and advance the head.
  - Otherwise rf_lde = 0 next cycle; rf_dsel and rf_din hold their last values.
  - rf_lde is high for exactly one cycle per popped entry.
- Latency:
  - Push at edge t into an empty, unheld queue -> pop at edge t+1 -> rf_lde high during cycle t+1..t+2 -> register file commits at edge t+2.
  - Sustained throughput: 1 write/cycle.
- Empty: no pop; rf_lde = 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. q_count tracks occupancy: +1 on push, -1 on pop, unchanged when both occur.
- Pending counter per register:
  - +1 on push to that rd.
  - -1 at each edge where rf_lde == 1 and rf_dsel == that register (commit).
  - Simultaneous increment and decrement of the same register leaves it unchanged.
  - Counters never overflow, since at most DEPTH+1 writes can be outstanding.
- Hazard: hzN = (pending[chk_sN] != 0). Covers both queued entries and the output stage. Purely combinational, no registered delay.
- R15: pc_load = rf_lde && (rf_dsel == 4'hF). The written value is rf_din.
- rf_hold freezes pops only; pushes continue until full. While held, the output stage shows rf_lde = 0.
- Program order is preserved: FIFO order equals commit order, including repeated writes to the same rd.

Optional Feature:
RF_WB_FWD_EN
- Defined: fwd_hitN = 1 when chk_sN matches the output stage (rf_lde high) or any valid FIFO entry. fwd_dataN = data of the youngest match, with priority tail-most FIFO entry > ... > head > output stage.
- Undefined: fwd_hitN = 0 and fwd_dataN = 32'h0 constantly; no comparator logic is built.
- Hazard outputs are identical either way.

Test Plan:
- Reset then a single push (rd = 10, data = 32'h000A0000) into an empty queue -> rf_lde = 1 with rf_dsel = 4'hA and rf_din = 32'h000A0000 exactly one cycle after the push edge. hz1 (chk_s1 = 10) is 1 from the push edge until the commit edge, then 0.
- rf_hold = 1; push 4 entries (rd 1..4, data 32'h11..32'h44) -> wb_ready = 0 and q_count = 4. Release hold -> four consecutive rf_lde cycles in order 1, 2, 3, 4, and wb_ready returns to 1 after the first pop.
- Two pushes to rd = 5 (32'hAAAA then 32'hBBBB) -> both commit in order. hz for register 5 stays 1 until the second commit. With RF_WB_FWD_EN, fwd_data = 32'hBBBB while both are pending.
- Push rd = 15, data = 32'h00000100 -> pc_load pulses for exactly one cycle, together with rf_lde and rf_din = 32'h100.
- Continuous push every cycle with the queue not held -> q_count stays <= 1, wb_ready stays 1, one rf_lde per cycle.
- Fill 3 entries, then drop clr low mid-stream -> outputs go to 0 immediately (asynchronously). After release, q_count = 0, all hz = 0, and no stale rf_lde occurs.

Source files
------------

// File: rtl/rf_writeback_queue_if.sv
// Write-back request bus: producer -> rf_writeback_queue.
// master = producer (execute/memory stages), slave = queue.
interface rf_writeback_queue_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: DEPTH-entry write-back FIFO in front of the 16x32 register
// file write port, with a per-register pending scoreboard for RAW hazard checks
// and a PC-redirect pulse on writes to R15.
// Optional feature: define RF_WB_FWD_EN to build the forwarding comparators
// (fwd_hitN / fwd_dataN); otherwise those outputs are tied to zero.

// Per-register pending counter: counts writes pushed but not yet committed.
module rf_wbq_pend #(
  parameter int CW = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output logic nz
);
  logic [CW-1:0] cnt;

  // inc on push to this register, dec on commit; both at once cancel out
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)              cnt <= '0;
    else if (inc && !dec)  cnt <= cnt + CW'(1);
    else if (dec && !inc)  cnt <= cnt - CW'(1);
  end

  assign nz = |cnt;
endmodule

module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+2)
) (
  input  logic                 clk,
  input  logic                 clr,
  rf_writeback_queue_if.slave  wb,
  input  logic                 rf_hold,
  output logic                 rf_lde,
  output logic [3:0]           rf_dsel,
  output logic [31:0]          rf_din,
  output logic                 pc_load,
  input  logic [3:0]           chk_s1,
  input  logic [3:0]           chk_s2,
  input  logic [3:0]           chk_s3,
  output logic                 hz1,
  output logic                 hz2,
  output logic                 hz3,
  output logic                 fwd_hit1,
  output logic                 fwd_hit2,
  output logic                 fwd_hit3,
  output logic [31:0]          fwd_data1,
  output logic [31:0]          fwd_data2,
  output logic [31:0]          fwd_data3,
  output logic [CW-1:0]        q_count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t        fifo [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic           full, push, pop;
  wb_ent_t        head;

  logic [2:0][3:0] chk;
  logic [15:0]     pend_nz;

  assign full        = (q_count == CW'(DEPTH));
  assign wb.wb_ready = !full;
  assign push        = wb.wb_valid && !full;
  // no same-cycle bypass: an entry pushed at edge t is first poppable at t+1
  assign pop         = (q_count != '0) && !rf_hold;
  assign head        = fifo[rptr];

  // storage: tail write only; contents need no reset since q_count gates use
  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= '{rd: wb.wb_rd, data: wb.wb_data};
  end

  // pointers wrap naturally at AW bits (DEPTH is a power of two)
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wptr    <= '0;
      rptr    <= '0;
      q_count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + CW'(1);
        2'b01:   q_count <= q_count - CW'(1);
        default: ;
      endcase
    end
  end

  // output stage: one-cycle load enable per popped entry, select/data hold otherwise
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rf_lde  <= 1'b0;
      rf_dsel <= 4'h0;
      rf_din  <= 32'h0;
      pc_load <= 1'b0;
    end else begin
      rf_lde  <= pop;
      pc_load <= pop && (head.rd == 4'hF);
      if (pop) begin
        rf_dsel <= head.rd;
        rf_din  <= head.data;
      end
    end
  end

  // scoreboard: one counter per architectural register
  for (genvar r = 0; r < 16; r++) begin : g_pend
    rf_wbq_pend #(.CW(CW)) u_pend (
      .clk (clk),
      .clr (clr),
      .inc (push   && (wb.wb_rd == 4'(r))),
      .dec (rf_lde && (rf_dsel  == 4'(r))),
      .nz  (pend_nz[r])
    );
  end

  assign chk = {chk_s3, chk_s2, chk_s1};
  assign hz1 = pend_nz[chk[0]];
  assign hz2 = pend_nz[chk[1]];
  assign hz3 = pend_nz[chk[2]];

  logic [2:0]       fhit;
  logic [2:0][31:0] fdat;

`ifdef RF_WB_FWD_EN
  // youngest match wins: scan output stage, then head..tail, later overrides
  always_comb begin
    fhit = '0;
    fdat = '0;
    for (int p = 0; p < 3; p++) begin
      if (rf_lde && (rf_dsel == chk[p])) begin
        fhit[p] = 1'b1;
        fdat[p] = rf_din;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < q_count) && (fifo[rptr + AW'(i)].rd == chk[p])) begin
          fhit[p] = 1'b1;
          fdat[p] = fifo[rptr + AW'(i)].data;
        end
      end
    end
  end
`else
  assign fhit = '0;
  assign fdat = '0;
`endif

  assign fwd_hit1  = fhit[0];
  assign fwd_hit2  = fhit[1];
  assign fwd_hit3  = fhit[2];
  assign fwd_data1 = fdat[0];
  assign fwd_data2 = fdat[1];
  assign fwd_data3 = fdat[2];
endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_rf_writeback_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+2);

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_queue_if wb();

  logic          rf_hold;
  logic          rf_lde, pc_load;
  logic [3:0]    rf_dsel;
  logic [31:0]   rf_din;
  logic [3:0]    chk_s1, chk_s2, chk_s3;
  logic          hz1, hz2, hz3;
  logic          fwd_hit1, fwd_hit2, fwd_hit3;
  logic [31:0]   fwd_data1, fwd_data2, fwd_data3;
  logic [CW-1:0] q_count;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .wb(wb), .rf_hold(rf_hold),
    .rf_lde(rf_lde), .rf_dsel(rf_dsel), .rf_din(rf_din), .pc_load(pc_load),
    .chk_s1(chk_s1), .chk_s2(chk_s2), .chk_s3(chk_s3),
    .hz1(hz1), .hz2(hz2), .hz3(hz3),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_hit3(fwd_hit3),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .fwd_data3(fwd_data3),
    .q_count(q_count)
  );

  // reference model: pending writes in program order plus the output stage
  typedef struct { logic [3:0] rd; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic        m_v;
  logic [3:0]  m_rd;
  logic [31:0] m_dat;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic int pend(input logic [3:0] r);
    int n = 0;
    foreach (mq[i]) if (mq[i].rd == r) n++;
    if (m_v && m_rd == r) n++;
    return n;
  endfunction

  task automatic port_chk(input string nm, input logic [3:0] s, input logic hz,
                          input logic fh, input logic [31:0] fd);
    logic        eh;
    logic [31:0] ed;
    chk({"hz", nm}, hz, pend(s) != 0);
    eh = 1'b0;
    ed = 32'h0;
`ifdef RF_WB_FWD_EN
    if (m_v && m_rd == s) begin eh = 1'b1; ed = m_dat; end
    foreach (mq[i]) if (mq[i].rd == s) begin eh = 1'b1; ed = mq[i].data; end
    chk({"fwd_hit", nm}, fh, eh);
    if (eh) chk({"fwd_data", nm}, fd, ed);
`else
    chk({"fwd_hit", nm}, fh, eh);
    chk({"fwd_data", nm}, fd, ed);
`endif
  endtask

  task automatic check_all();
    chk("q_count",  q_count,     mq.size());
    chk("wb_ready", wb.wb_ready, mq.size() < DEPTH);
    chk("rf_lde",   rf_lde,      m_v);
    chk("rf_dsel",  rf_dsel,     m_rd);
    chk("rf_din",   rf_din,      m_dat);
    chk("pc_load",  pc_load,     m_v && m_rd == 4'hF);
    port_chk("1", chk_s1, hz1, fwd_hit1, fwd_data1);
    port_chk("2", chk_s2, hz2, fwd_hit2, fwd_data2);
    port_chk("3", chk_s3, hz3, fwd_hit3, fwd_data3);
  endtask

  // one clock: model decides push/pop from pre-edge inputs, then compare
  task automatic step();
    bit   do_push, do_pop;
    ent_t e;
    do_push = wb.wb_valid && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && !rf_hold;
    @(posedge clk);
    if (do_pop) begin
      e     = mq.pop_front();
      m_v   = 1'b1;
      m_rd  = e.rd;
      m_dat = e.data;
    end else m_v = 1'b0;
    if (do_push) mq.push_back('{wb.wb_rd, wb.wb_data});
    #2;
    check_all();
  endtask

  task automatic model_reset();
    mq.delete();
    m_v   = 1'b0;
    m_rd  = 4'h0;
    m_dat = 32'h0;
  endtask

  task automatic push_in(input logic [3:0] rd, input logic [31:0] d);
    wb.wb_valid = 1'b1;
    wb.wb_rd    = rd;
    wb.wb_data  = d;
  endtask

  initial begin
    wb.wb_valid = 1'b0;
    wb.wb_rd    = 4'h0;
    wb.wb_data  = 32'h0;
    rf_hold     = 1'b0;
    chk_s1 = 4'h0; chk_s2 = 4'h0; chk_s3 = 4'h0;
    model_reset();

    // reset state
    #12;
    check_all();
    @(negedge clk) clr = 1'b1;
    step();

    // single push into empty queue: one-cycle latency to rf_lde
    chk_s1 = 4'hA;
    push_in(4'hA, 32'h000A0000);
    step();
    chk("t1_lde_push", rf_lde, 1'b0);
    chk("t1_hz_push",  hz1,    1'b1);
    wb.wb_valid = 1'b0;
    step();
    chk("t1_lde",  rf_lde,  1'b1);
    chk("t1_dsel", rf_dsel, 4'hA);
    chk("t1_din",  rf_din,  32'h000A0000);
    chk("t1_hz_out", hz1, 1'b1);
    step();
    chk("t1_hz_done", hz1, 1'b0);

    // hold while filling, then drain in order
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_in(4'(i), 32'(i * 'h11));
      step();
    end
    wb.wb_valid = 1'b0;
    step();
    chk("hold_ready", wb.wb_ready, 1'b0);
    chk("hold_count", q_count, 4);
    rf_hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_dsel", rf_dsel, 4'(i));
      chk("drain_lde",  rf_lde,  1'b1);
      chk("drain_ready", wb.wb_ready, 1'b1);
    end
    step();

    // two writes to the same register, in order
    chk_s2 = 4'h5;
    push_in(4'h5, 32'hAAAA);
    step();
    push_in(4'h5, 32'hBBBB);
    step();
    wb.wb_valid = 1'b0;
    chk("raw_hz_both", hz2, 1'b1);
`ifdef RF_WB_FWD_EN
    chk("raw_fwd_young", fwd_data2, 32'hBBBB);
`endif
    step();
    chk("raw_din2", rf_din, 32'hBBBB);
    chk("raw_hz_one", hz2, 1'b1);
    step();
    chk("raw_hz_none", hz2, 1'b0);

    // R15 write -> PC redirect pulse
    push_in(4'hF, 32'h00000100);
    step();
    wb.wb_valid = 1'b0;
    step();
    chk("r15_pc",  pc_load, 1'b1);
    chk("r15_din", rf_din,  32'h100);
    step();
    chk("r15_pc_off", pc_load, 1'b0);

    // continuous push, no hold: q_count stays <= 1
    for (int i = 0; i < 8; i++) begin
      push_in(4'($urandom_range(0, 14)), $urandom);
      step();
      chk("cont_q", q_count <= 1, 1'b1);
      if (i > 0) chk("cont_lde", rf_lde, 1'b1);
    end
    wb.wb_valid = 1'b0;
    step();
    step();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      wb.wb_valid = ($urandom_range(0, 99) < 70);
      wb.wb_rd    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      wb.wb_data  = $urandom;
      rf_hold     = ($urandom_range(0, 3) == 0);
      chk_s1 = 4'($urandom_range(0, 15));
      chk_s2 = 4'($urandom_range(0, 15));
      chk_s3 = wb.wb_rd;
      step();
    end
    wb.wb_valid = 1'b0;
    rf_hold = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) step();

    // async reset mid-stream discards in-flight writes
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_in(4'(6 + i), 32'(32'hC0 + i));
      step();
    end
    wb.wb_valid = 1'b0;
    rf_hold = 1'b0;
    chk_s1 = 4'h6; chk_s2 = 4'h7; chk_s3 = 4'h8;
    step();
    chk("rst_pre_lde", rf_lde, 1'b1);
    #1 clr = 1'b0;
    #1;
    model_reset();
    chk("rst_async_lde",   rf_lde,  1'b0);
    chk("rst_async_dsel",  rf_dsel, 4'h0);
    chk("rst_async_din",   rf_din,  32'h0);
    chk("rst_async_count", q_count, 0);
    check_all();
    @(negedge clk) clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_stale", rf_lde, 1'b0);
    end
    chk("rst_hz1", hz1, 1'b0);
    chk("rst_hz2", hz2, 1'b0);
    chk("rst_hz3", hz3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
